// File: rtl/boot_pkg.sv
// Shared definitions for the flash boot loader: FSM encoding, slot kinds,
// the flash READ opcode and the chip-select setup/hold lengths.
package boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_A2,
    ST_A1,
    ST_A0,
    ST_PRIME,
    ST_READ,
    ST_WRITE,
    ST_CS_HOLD,
    ST_DONE
  } boot_state_t;

  typedef enum logic {
    SLOT_SEND = 1'b0,
    SLOT_RECV = 1'b1
  } slot_kind_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         CS_SETUP_CYC   = 2;
  localparam int         CS_HOLD_CYC    = 2;

endpackage

// File: rtl/spi_slot_timer.sv
// Byte-slot timer for the SPI engine: strobe high for STROBE_CYC clocks,
// then low for GAP_CYC clocks, repeating while go is held.
module spi_slot_timer
  import boot_pkg::*;
#(
  parameter int STROBE_CYC = 18,
  parameter int GAP_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  slot_kind_t kind,
  output logic       spi_send,
  output logic       spi_recv,
  output logic       sample_en,
  output logic       gap_first,
  output logic       slot_end
);

  localparam int SLOT_CYC = STROBE_CYC + GAP_CYC;

  logic [4:0] phase;
  logic       strobe;

  always_ff @(posedge clk) begin
    if (rst || !go) begin
      phase <= '0;
    end else if (slot_end) begin
      phase <= '0;
    end else begin
      phase <= phase + 5'd1;
    end
  end

  // The engine presents its returned byte on the first clock of a recv slot,
  // so it is taken one clock later.
  always_comb begin
    strobe    = go && (phase < 5'(STROBE_CYC));
    spi_send  = strobe && (kind == SLOT_SEND);
    spi_recv  = strobe && (kind == SLOT_RECV);
    sample_en = go && (kind == SLOT_RECV) && (phase == 5'd1);
    gap_first = go && (phase == 5'(STROBE_CYC));
    slot_end  = go && (phase == 5'(SLOT_CYC - 1));
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads LENGTH bytes from SPI flash at FLASH_ADDR through
// the SPI byte engine and writes them to SRAM starting at SRAM_BASE.
//
// state     | meaning
// IDLE      | waiting for start
// CS_SETUP  | flash selected, strobes idle
// CMD       | send slot carrying the READ opcode
// A2/A1/A0  | send slots carrying the 24-bit flash address, MSB first
// PRIME     | first recv slot, returned byte is stale and dropped
// READ      | recv slot, returned byte latched into sram_data
// WRITE     | gap of the READ slot after the SRAM write strobe
// CS_HOLD   | strobes idle before deselecting the flash
// DONE      | load complete, boot may proceed
module flash_boot_loader
  import boot_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h058000,
  parameter int          LENGTH     = 16384,
  parameter logic [20:0] SRAM_BASE  = 21'h000000,
  parameter int          STROBE_CYC = 18,
  parameter int          GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        boot_done,
  output logic        flash_cs_n,
  output logic        spi_send,
  output logic        spi_recv,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data,
  output logic        sram_we_n
);

  boot_state_t state, next_state;
  logic [1:0]  cs_cnt;
  logic [15:0] byte_cnt;
  logic        go;
  slot_kind_t  kind;
  logic        sample_en, gap_first, slot_end;
  logic        start_ok;

  spi_slot_timer #(
    .STROBE_CYC (STROBE_CYC),
    .GAP_CYC    (GAP_CYC)
  ) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .kind      (kind),
    .spi_send  (spi_send),
    .spi_recv  (spi_recv),
    .sample_en (sample_en),
    .gap_first (gap_first),
    .slot_end  (slot_end)
  );

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cs_cnt <= 2'd0;
    end else begin
      state  <= next_state;
      cs_cnt <= (next_state != state) ? 2'd0 : cs_cnt + 2'd1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_CS_SETUP;
      ST_CS_SETUP:      if (cs_cnt == 2'(CS_SETUP_CYC - 1)) next_state = ST_CMD;
      ST_CMD:           if (slot_end) next_state = ST_A2;
      ST_A2:            if (slot_end) next_state = ST_A1;
      ST_A1:            if (slot_end) next_state = ST_A0;
      ST_A0:            if (slot_end) next_state = ST_PRIME;
      ST_PRIME:         if (slot_end) next_state = ST_READ;
      ST_READ:          if (gap_first) next_state = ST_WRITE;
      ST_WRITE: begin
        if (slot_end) begin
          next_state = (byte_cnt == 16'(LENGTH - 1)) ? ST_CS_HOLD : ST_READ;
        end
      end
      ST_CS_HOLD:       if (cs_cnt == 2'(CS_HOLD_CYC - 1)) next_state = ST_DONE;
      default:          next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    boot_done  = 1'b0;
    flash_cs_n = 1'b0;
    go         = 1'b0;
    kind       = SLOT_SEND;
    spi_tx     = 8'h00;
    unique case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        flash_cs_n = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b0;
        boot_done  = 1'b1;
        flash_cs_n = 1'b1;
      end
      ST_CMD: begin
        go     = 1'b1;
        spi_tx = FLASH_CMD_READ;
      end
      ST_A2: begin
        go     = 1'b1;
        spi_tx = FLASH_ADDR[23:16];
      end
      ST_A1: begin
        go     = 1'b1;
        spi_tx = FLASH_ADDR[15:8];
      end
      ST_A0: begin
        go     = 1'b1;
        spi_tx = FLASH_ADDR[7:0];
      end
      ST_PRIME, ST_READ, ST_WRITE: begin
        go   = 1'b1;
        kind = SLOT_RECV;
      end
      ST_CS_SETUP, ST_CS_HOLD: ;
      default: begin
        busy       = 1'b0;
        flash_cs_n = 1'b1;
      end
    endcase
  end

  // Write strobe sits on the first gap clock, so address and data are already
  // settled a clock before and stay put until the slot ends.
  assign sram_we_n = !((state == ST_READ) && gap_first);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 16'd0;
      sram_addr <= SRAM_BASE;
      sram_data <= 8'h00;
    end else begin
      if (start_ok) begin
        byte_cnt  <= 16'd0;
        sram_addr <= SRAM_BASE;
      end else if ((state == ST_WRITE) && slot_end) begin
        byte_cnt  <= byte_cnt + 16'd1;
        sram_addr <= sram_addr + 21'd1;
      end
      if ((state == ST_READ) && sample_en) begin
        sram_data <= spi_rx;
      end
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: two instances (LENGTH=4 at a wrapping SRAM base,
// LENGTH=1 at base 0) driven by a pipelined SPI engine / flash / SRAM model.
module tb_flash_boot_loader;

  localparam logic [23:0] FADDR = 24'h058000;
  localparam int          LEN0  = 4;
  localparam int          LEN1  = 1;
  localparam logic [20:0] BASE0 = 21'h1FFFFE;
  localparam logic [20:0] BASE1 = 21'h000000;
  localparam int          SLOT  = 20;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        start      [2];
  logic        busy       [2];
  logic        boot_done  [2];
  logic        flash_cs_n [2];
  logic        spi_send   [2];
  logic        spi_recv   [2];
  logic [7:0]  spi_tx     [2];
  logic [7:0]  spi_rx     [2];
  logic [20:0] sram_addr  [2];
  logic [7:0]  sram_data  [2];
  logic        sram_we_n  [2];

  int n_checks = 0;
  int n_pass   = 0;

  // model / observation state, written only by the monitor process
  logic [7:0]  fdata [2][8];
  logic [7:0]  pend [2];
  logic [7:0]  mosi [2][4];
  logic [20:0] wr_addr [2][8];
  logic [7:0]  wr_data [2][8];
  int rd_idx [2], mosi_cnt [2], send_rises [2], recv_rises [2], wr_cnt [2];
  int hi_run [2], lo_run [2], hi_min [2], hi_max [2], gap_min [2];
  int both_cnt [2], tx_bad [2], we_bad [2], we_run [2];
  logic prev_hi [2], prev_send [2], prev_recv [2], prev_busy [2], prev_we_lo [2], had_fall [2];
  logic [7:0]  tx_hold [2], last_data [2];
  logic [20:0] last_addr [2];

  always #5 clk = ~clk;

  flash_boot_loader #(
    .FLASH_ADDR(FADDR), .LENGTH(LEN0), .SRAM_BASE(BASE0), .STROBE_CYC(18), .GAP_CYC(2)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .boot_done(boot_done[0]),
    .flash_cs_n(flash_cs_n[0]), .spi_send(spi_send[0]), .spi_recv(spi_recv[0]),
    .spi_tx(spi_tx[0]), .spi_rx(spi_rx[0]), .sram_addr(sram_addr[0]),
    .sram_data(sram_data[0]), .sram_we_n(sram_we_n[0])
  );

  flash_boot_loader #(
    .FLASH_ADDR(FADDR), .LENGTH(LEN1), .SRAM_BASE(BASE1), .STROBE_CYC(18), .GAP_CYC(2)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .boot_done(boot_done[1]),
    .flash_cs_n(flash_cs_n[1]), .spi_send(spi_send[1]), .spi_recv(spi_recv[1]),
    .spi_tx(spi_tx[1]), .spi_rx(spi_rx[1]), .sram_addr(sram_addr[1]),
    .sram_data(sram_data[1]), .sram_we_n(sram_we_n[1])
  );

  // SPI engine + flash + SRAM observer, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i] !== 1'b0) begin
        prev_send[i] = 1'b0; prev_recv[i] = 1'b0; prev_hi[i] = 1'b0;
        prev_busy[i] = 1'b0; prev_we_lo[i] = 1'b0; spi_rx[i] = 8'h00;
      end else begin
        if (busy[i] && !prev_busy[i]) begin
          rd_idx[i] = 0; mosi_cnt[i] = 0; send_rises[i] = 0; recv_rises[i] = 0; wr_cnt[i] = 0;
          hi_min[i] = 1000; hi_max[i] = 0; gap_min[i] = 1000; both_cnt[i] = 0;
          tx_bad[i] = 0; we_bad[i] = 0; had_fall[i] = 1'b0;
          hi_run[i] = 0; lo_run[i] = 0; we_run[i] = 0; pend[i] = 8'hEE;
        end
        if (spi_send[i] && spi_recv[i]) both_cnt[i]++;
        if (spi_send[i]) begin
          if (!prev_send[i]) begin
            send_rises[i]++;
            tx_hold[i] = spi_tx[i];
            if (mosi_cnt[i] < 4) mosi[i][mosi_cnt[i]] = spi_tx[i];
            mosi_cnt[i]++;
          end else if (spi_tx[i] !== tx_hold[i]) begin
            tx_bad[i]++;
          end
        end
        // engine returns the byte shifted during the previous recv slot
        if (spi_recv[i] && !prev_recv[i]) begin
          recv_rises[i]++;
          spi_rx[i] = pend[i];
          pend[i] = (rd_idx[i] < 8) ? fdata[i][rd_idx[i]] : 8'h00;
          rd_idx[i]++;
        end
        if (spi_send[i] || spi_recv[i]) begin
          if (!prev_hi[i]) begin
            if (had_fall[i] && lo_run[i] < gap_min[i]) gap_min[i] = lo_run[i];
            hi_run[i] = 0;
          end
          hi_run[i]++;
        end else begin
          if (prev_hi[i]) begin
            if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
            if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
            had_fall[i] = 1'b1;
            lo_run[i] = 0;
          end
          lo_run[i]++;
        end
        if (!sram_we_n[i]) begin
          if (!prev_we_lo[i]) begin
            if (sram_addr[i] !== last_addr[i] || sram_data[i] !== last_data[i]) we_bad[i]++;
            if (wr_cnt[i] < 8) begin
              wr_addr[i][wr_cnt[i]] = sram_addr[i];
              wr_data[i][wr_cnt[i]] = sram_data[i];
            end
            wr_cnt[i]++;
            we_run[i] = 0;
          end
          we_run[i]++;
        end else if (prev_we_lo[i]) begin
          if (we_run[i] != 1) we_bad[i]++;
          if (sram_addr[i] !== last_addr[i] || sram_data[i] !== last_data[i]) we_bad[i]++;
        end
        prev_hi[i]    = spi_send[i] || spi_recv[i];
        prev_send[i]  = spi_send[i];
        prev_recv[i]  = spi_recv[i];
        prev_busy[i]  = busy[i];
        prev_we_lo[i] = !sram_we_n[i];
      end
      last_addr[i] = sram_addr[i];
      last_data[i] = sram_data[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input int i, input logic [20:0] base);
    string p;
    p = $sformatf("u%0d.rst_", i);
    check({p, "busy"},      32'(busy[i]),       32'd0);
    check({p, "boot_done"}, 32'(boot_done[i]),  32'd0);
    check({p, "cs_n"},      32'(flash_cs_n[i]), 32'd1);
    check({p, "send"},      32'(spi_send[i]),   32'd0);
    check({p, "recv"},      32'(spi_recv[i]),   32'd0);
    check({p, "tx"},        32'(spi_tx[i]),     32'd0);
    check({p, "addr"},      32'(sram_addr[i]),  32'(base));
    check({p, "data"},      32'(sram_data[i]),  32'd0);
    check({p, "we_n"},      32'(sram_we_n[i]),  32'd1);
  endtask

  // pulses start, optionally pulses it again once recv slot number mid has begun
  task automatic run_load(input int i, input int mid, output int bc);
    int  n;
    bit  pulsed;
    string p;
    p = $sformatf("u%0d.", i);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    check({p, "start_busy"}, 32'(busy[i]),      32'd1);
    check({p, "start_done"}, 32'(boot_done[i]), 32'd0);
    bc = 1; n = 0; pulsed = 1'b0;
    while (boot_done[i] !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      start[i] = (mid > 0) && !pulsed && (recv_rises[i] == mid);
      if (start[i]) pulsed = 1'b1;
      if (busy[i]) bc++;
    end
    start[i] = 1'b0;
    check({p, "done_in_time"}, 32'(boot_done[i]), 32'd1);
  endtask

  task automatic check_load(input int i, input int len, input logic [20:0] base, input int bc);
    string p;
    logic [23:0] fa;
    fa = FADDR;
    p = $sformatf("u%0d.", i);
    check({p, "busy_end"},    32'(busy[i]),       32'd0);
    check({p, "cs_n_end"},    32'(flash_cs_n[i]), 32'd1);
    check({p, "busy_cycles"}, 32'(bc),            32'(2 + (5 + len) * SLOT + 2));
    check({p, "mosi_cmd"},    32'(mosi[i][0]),    32'h03);
    check({p, "mosi_a2"},     32'(mosi[i][1]),    32'(fa[23:16]));
    check({p, "mosi_a1"},     32'(mosi[i][2]),    32'(fa[15:8]));
    check({p, "mosi_a0"},     32'(mosi[i][3]),    32'(fa[7:0]));
    check({p, "send_slots"},  32'(send_rises[i]), 32'd4);
    check({p, "recv_slots"},  32'(recv_rises[i]), 32'(len + 1));
    check({p, "we_pulses"},   32'(wr_cnt[i]),     32'(len));
    for (int k = 0; k < len && k < 8; k++) begin
      check($sformatf("u%0d.wr_addr%0d", i, k), 32'(wr_addr[i][k]),
            32'((int'(base) + k) % (1 << 21)));
      check($sformatf("u%0d.wr_data%0d", i, k), 32'(wr_data[i][k]), 32'(fdata[i][k]));
    end
    check({p, "strobe_hi_min"}, 32'(hi_min[i]),       32'd18);
    check({p, "strobe_hi_max"}, 32'(hi_max[i]),       32'd18);
    check({p, "gap_ge2"},       32'(gap_min[i] >= 2), 32'd1);
    check({p, "both_high"},     32'(both_cnt[i]),     32'd0);
    check({p, "tx_unstable"},   32'(tx_bad[i]),       32'd0);
    check({p, "we_shape"},      32'(we_bad[i]),       32'd0);
  endtask

  initial begin
    int bc;
    int n;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    fdata[0][0] = 8'hAA; fdata[0][1] = 8'h55; fdata[0][2] = 8'h01; fdata[0][3] = 8'hFF;
    for (int k = 4; k < 8; k++) fdata[0][k] = 8'($urandom);
    fdata[1][0] = 8'h5A;
    for (int k = 1; k < 8; k++) fdata[1][k] = 8'($urandom);
    repeat (3) @(posedge clk);
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check_reset(0, BASE0);
    check_reset(1, BASE1);

    // fixed pattern into an SRAM window that wraps past the top
    run_load(0, 0, bc);
    check_load(0, LEN0, BASE0, bc);

    // restart from DONE with random data; stray start during first READ slot
    for (int k = 0; k < 8; k++) fdata[0][k] = 8'($urandom);
    run_load(0, 2, bc);
    check_load(0, LEN0, BASE0, bc);

    // reset during the third READ slot
    for (int k = 0; k < 8; k++) fdata[0][k] = 8'($urandom);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    n = 0;
    while (recv_rises[0] < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("u0.third_read_reached", 32'(recv_rises[0] >= 4), 32'd1);
    repeat (5) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check_reset(0, BASE0);
    rst[0] = 1'b0;
    @(negedge clk);

    // full load after the abort, then an identical one restarted from DONE
    run_load(0, 0, bc);
    check_load(0, LEN0, BASE0, bc);
    run_load(0, 0, bc);
    check_load(0, LEN0, BASE0, bc);

    // single-byte load
    run_load(1, 0, bc);
    check_load(1, LEN1, BASE1, bc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Boot-time sequencer directly upstream of the SPI byte engine (clk-domain SPI master driven by send/receive strobes).
- On start, selects the SPI flash and issues READ (0x03) plus a 24-bit address, then streams LENGTH bytes into SRAM.
- Generates the engine's send/receive strobes and consumes its returned byte.
- Signals completion so the reset/boot controller can release the Z80.

Parameters:
- FLASH_ADDR, 24'h058000, first flash byte to read.
- LENGTH, 16384, bytes to copy (1..65535).
- SRAM_BASE, 21'h000000, SRAM address receiving byte 0.
- STROBE_CYC, 18, clocks a send/recv strobe is held high (must be ≥17).
- GAP_CYC, 2, clocks a strobe is held low between bytes (must be ≥2).

Ports:
- clk  in  1  system clock (7 MHz), same clock as the SPI engine
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load
- busy  out  1  high from start accept until DONE
- boot_done  out  1  high in DONE; cleared by an accepted start or by rst
- flash_cs_n  out  1  SPI flash chip select, active low
- spi_send  out  1  to engine's send request
- spi_recv  out  1  to engine's receive request
- spi_tx  out  8  byte to the engine
- spi_rx  in  8  byte from the engine; valid only while spi_recv=1
- sram_addr  out  21  SRAM address
- sram_data  out  8  SRAM write data
- sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Reset values: busy=0, boot_done=0, flash_cs_n=1, spi_send=0, spi_recv=0, spi_tx=0, sram_addr=SRAM_BASE, sram_data=0, sram_we_n=1. rst mid-load aborts immediately to IDLE with these values. No partial-byte completion.
- Strobe slot: one line high for STROBE_CYC clocks, then both low for GAP_CYC clocks. Total slot = STROBE_CYC+GAP_CYC = 20 clocks at defaults. spi_send and spi_recv are never high together. spi_tx is stable for the whole send slot.
- Receive is pipelined by one byte: the engine returns at the start of recv slot N the byte shifted during slot N-1. The first recv slot (PRIME) is therefore discarded. LENGTH+1 recv slots are issued in total.
- spi_rx is sampled on the 2nd clock of each recv slot (phase counter = 1).
- States:
  - IDLE: waits for start. On start: busy=1, boot_done=0, byte counter=0, sram_addr=SRAM_BASE.
  - CS_SETUP: flash_cs_n=0 for 2 clocks.
  - CMD: send slot, spi_tx=0x03.
  - A2, A1, A0: send slots carrying FLASH_ADDR[23:16], [15:8], [7:0].
  - PRIME: one recv slot, data ignored.
  - READ: recv slot; the sampled byte is latched into sram_data.
  - WRITE: occupies the gap clocks of that READ slot. sram_we_n=0 for exactly 1 clock (gap clock 0), with address and data stable 1 clock before and after. sram_addr increments after we_n returns high. Counter increments.
  - Transition out of READ/WRITE: back to READ until counter==LENGTH, then CS_HOLD.
  - CS_HOLD: strobes low, 2 clocks, then flash_cs_n=1.
  - DONE: busy=0, boot_done=1. A start here restarts the load.
- start while busy is ignored.
- sram_addr wraps modulo 2^21. The counter is 16 bits. LENGTH=1 gives exactly one SRAM write.
- Load time = 2 + 5 slots (CMD, A2, A1, A0, PRIME) + LENGTH slots + 2 clocks.

Decomposition:
- Shared package (boot_pkg): state encoding, the FLASH_CMD_READ=8'h03 constant, and the CS setup/hold clock counts.
- One natural sub-module, spi_slot_timer: 5-bit phase counter. Inputs go/kind; outputs spi_send, spi_recv, sample_en, gap_first, slot_end.

Test Plan:
- rst, then start with bench = flash model + real SPI engine, FLASH_ADDR=0x058000, LENGTH=4, flash bytes AA 55 01 FF → MOSI carries 03 05 80 00. SRAM gets AA@0, 55@1, 01@2, FF@3. Exactly 4 we_n pulses. boot_done=1, flash_cs_n=1.
- Strobe timing check → each spi_send/spi_recv high exactly 18 clocks, low ≥2. Never both high. Exactly 5 recv slots for LENGTH=4 (first discarded).
- SRAM_BASE=21'h1FFFFE, LENGTH=4 → writes at 1FFFFE, 1FFFFF, 000000, 000001.
- rst asserted during 3rd READ slot → next clock all outputs at reset values. A new start then completes a full correct load.
- start pulsed during READ → ignored, byte count unchanged. start in DONE → boot_done drops and a second identical load completes.
- LENGTH=1, flash byte 0x5A → single write 5A@SRAM_BASE. busy high for exactly 2+6×20+2 clocks.
